// File: rtl/gcd_ctrl_pkg.sv
// Shared constants for the GCD control path: FSM state encodings,
// datapath mux select values and a comparator sanity helper.
package gcd_ctrl_pkg;

   // FSM state encodings (3-bit, kept as plain constants for legacy tools)
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_A  = 3'd1;
   localparam logic [2:0] ST_LOAD_B  = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Subtractor operand selects
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Register input bus select
   localparam logic SEL_BUS_DATA = 1'b1;
   localparam logic SEL_BUS_SUB  = 1'b0;

   // Exactly one comparator flag must be set for the datapath to be trusted.
   function automatic logic flags_one_hot(input logic lt, input logic gt, input logic eq);
      return $onehot({lt, gt, eq});
   endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction iteration counter: synchronous clear, increment, saturation
// at MAX_ITER and a terminal flag used for the timeout abort.
module gcd_iter_counter #(
   parameter int MAX_ITER = 65535,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   assign at_max = (count == CNT_W'(MAX_ITER));

   // Count subtractions; clear wins, and the value sticks once it hits MAX_ITER.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state updates in clocked blocks use <= so every flop samples pre-edge values.
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/gcd_sequencer.sv
// Control FSM for the subtractive GCD datapath. Accepts an operand pair,
// loads A then B over the shared data bus, steers A-=B / B-=A from the
// comparator flags until they are equal, then holds done plus status.
module gcd_sequencer
   import gcd_ctrl_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MAX_ITER = 65535,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             abort,
   input  logic             lt,
   input  logic             gt,
   input  logic             eq,
   output logic [WIDTH-1:0] data_in,
   output logic             ldA,
   output logic             ldB,
   output logic             sel1,
   output logic             sel2,
   output logic             sel_in,
   output logic             done,
   output logic             err_zero,
   output logic             err_timeout,
   output logic             err_flags,
   output logic [CNT_W-1:0] iter_count
);

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic             ready_q;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             accept;
   logic             cnt_inc;
   logic             cnt_at_max;
   logic             set_zero;
   logic             set_timeout;
   logic             set_flags;

   // in_ready is registered so it stays low while reset is held and rises
   // on the first edge after release.
   assign in_ready = ready_q;
   assign accept   = in_valid && ready_q;

   gcd_iter_counter #(
      .MAX_ITER (MAX_ITER),
      .CNT_W    (CNT_W)
   ) u_iter_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept && !abort),
      .inc    (cnt_inc && !abort),
      .count  (iter_count),
      .at_max (cnt_at_max)
   );

   // Next-state and output decode; COMPUTE outputs are Mealy on the flags.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      data_in     = '0;
      ldA         = 1'b0;
      ldB         = 1'b0;
      sel1        = SEL_A;
      sel2        = SEL_A;
      sel_in      = SEL_BUS_SUB;
      cnt_inc     = 1'b0;
      set_zero    = 1'b0;
      set_timeout = 1'b0;
      set_flags   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) state_d = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            data_in = op_a;
            sel_in  = SEL_BUS_DATA;
            ldA     = 1'b1;
            state_d = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            data_in = op_b;
            sel_in  = SEL_BUS_DATA;
            ldB     = 1'b1;
            if (op_a == '0 || op_b == '0) begin
               set_zero = 1'b1;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (!flags_one_hot(lt, gt, eq)) begin
               set_flags = 1'b1;
               state_d   = ST_DONE;
            end else if (eq) begin
               state_d = ST_DONE;
            end else if (cnt_at_max) begin
               set_timeout = 1'b1;
               state_d     = ST_DONE;
            end else if (gt) begin
               sel1    = SEL_A;
               sel2    = SEL_B;
               ldA     = 1'b1;
               cnt_inc = 1'b1;
            end else begin
               sel1    = SEL_B;
               sel2    = SEL_A;
               ldB     = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort beats everything, including a same-cycle accept.
      if (abort) state_d = ST_IDLE;
   end

   // State, ready flag, operand holding registers and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the operand holding regs are reset too, so data_in is a known 0 out of reset.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         done        <= 1'b0;
         err_zero    <= 1'b0;
         err_timeout <= 1'b0;
         err_flags   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
         if (abort) begin
            done        <= 1'b0;
            err_zero    <= 1'b0;
            err_timeout <= 1'b0;
            err_flags   <= 1'b0;
         end else if (accept) begin
            op_a        <= in_a;
            op_b        <= in_b;
            done        <= 1'b0;
            err_zero    <= 1'b0;
            err_timeout <= 1'b0;
            err_flags   <= 1'b0;
         end else begin
            if (state_d == ST_DONE && state_q != ST_DONE) done <= 1'b1;
            if (set_zero)    err_zero    <= 1'b1;
            if (set_timeout) err_timeout <= 1'b1;
            if (set_flags)   err_flags   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench: gcd_sequencer driving a behavioural GCD datapath
// (A/B registers, operand muxes, subtractor, comparator). Latency is the
// count of rising edges after the accept edge up to and including the
// first edge at which done is already high.
module tb_gcd_sequencer;

   localparam int WIDTH    = 16;
   localparam int MAX_ITER = 8;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             abort;
   logic             lt, gt, eq;
   logic [WIDTH-1:0] data_in;
   logic             ldA, ldB, sel1, sel2, sel_in;
   logic             done, err_zero, err_timeout, err_flags;
   logic [CNT_W-1:0] iter_count;

   // Datapath model
   logic [WIDTH-1:0] reg_a = '0;
   logic [WIDTH-1:0] reg_b = '0;
   logic [WIDTH-1:0] sub_out;
   logic [WIDTH-1:0] bus;
   logic             force_bad;

   int n_tests = 0;
   int n_fail  = 0;
   int bad_ld  = 0;

   int               lat;
   int               pulses;
   logic [WIDTH-1:0] d1, d2;

   always #5 clk = ~clk;

   assign sub_out = (sel1 ? reg_b : reg_a) - (sel2 ? reg_b : reg_a);
   assign bus     = sel_in ? data_in : sub_out;
   assign lt      = force_bad ? 1'b1 : (reg_a < reg_b);
   assign gt      = force_bad ? 1'b1 : (reg_a > reg_b);
   assign eq      = force_bad ? 1'b0 : (reg_a == reg_b);

   always_ff @(posedge clk) begin
      if (ldA) reg_a <= bus;
      if (ldB) reg_b <= bus;
   end

   // Load enables must never overlap and must be idle while done is shown.
   always @(negedge clk) begin
      if (rst_n && ldA && ldB) bad_ld <= bad_ld + 1;
      if (rst_n && done && (ldA || ldB)) bad_ld <= bad_ld + 1;
   end

   gcd_sequencer #(
      .WIDTH    (WIDTH),
      .MAX_ITER (MAX_ITER),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .abort       (abort),
      .lt          (lt),
      .gt          (gt),
      .eq          (eq),
      .data_in     (data_in),
      .ldA         (ldA),
      .ldB         (ldB),
      .sel1        (sel1),
      .sel2        (sel2),
      .sel_in      (sel_in),
      .done        (done),
      .err_zero    (err_zero),
      .err_timeout (err_timeout),
      .err_flags   (err_flags),
      .iter_count  (iter_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one operand pair, then watch until done (bounded); -1 means it never came.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat_o, output int pulses_o,
                         output logic [WIDTH-1:0] d1_o, output logic [WIDTH-1:0] d2_o);
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat_o = -1; pulses_o = 0; d1_o = '0; d2_o = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) d1_o = data_in;
         if (c == 2) d2_o = data_in;
         if (ldA || ldB) pulses_o++;
         if (done === 1'b1) begin
            lat_o = c;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0; force_bad = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_in_ready",   in_ready,   0);
      check("rst_done",       done,       0);
      check("rst_data_in",    data_in,    0);
      check("rst_ld",         {ldA, ldB, sel1, sel2, sel_in}, 0);
      check("rst_errs",       {err_zero, err_timeout, err_flags}, 0);
      check("rst_iter_count", iter_count, 0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1 check("ready_after_release", in_ready, 1);

      // (48,18): 4 subtractions, gcd 6
      run_op(16'd48, 16'd18, lat, pulses, d1, d2);
      check("g48_latency", lat,        8);
      check("g48_load_a",  d1,         48);
      check("g48_load_b",  d2,         18);
      check("g48_reg_a",   reg_a,      6);
      check("g48_reg_b",   reg_b,      6);
      check("g48_iter",    iter_count, 4);
      check("g48_pulses",  pulses,     6);
      check("g48_errs",    {err_zero, err_timeout, err_flags}, 0);
      check("g48_ready",   in_ready,   1);

      // (7,7): equal at the first compute cycle
      run_op(16'd7, 16'd7, lat, pulses, d1, d2);
      check("g77_latency", lat,        4);
      check("g77_iter",    iter_count, 0);
      check("g77_pulses",  pulses,     2);
      check("g77_reg_a",   reg_a,      7);
      check("g77_errs",    {err_zero, err_timeout, err_flags}, 0);

      // Zero operands
      run_op(16'd0, 16'd9, lat, pulses, d1, d2);
      check("z09_latency",  lat,        3);
      check("z09_err_zero", err_zero,   1);
      check("z09_iter",     iter_count, 0);
      run_op(16'd0, 16'd0, lat, pulses, d1, d2);
      check("z00_latency",  lat,        3);
      check("z00_err_zero", err_zero,   1);

      // Timeout: 8 subtractions of 1 from 100 leave 92
      run_op(16'd100, 16'd1, lat, pulses, d1, d2);
      check("to_latency",  lat,         12);
      check("to_err",      err_timeout, 1);
      check("to_reg_a",    reg_a,       92);
      check("to_reg_b",    reg_b,       1);
      check("to_iter",     iter_count,  8);
      check("to_pulses",   pulses,      10);
      check("to_err_zero", err_zero,    0);

      // Bad comparator flags in the first compute cycle
      @(negedge clk);
      in_a = 16'd20; in_b = 16'd6; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      force_bad = 1'b1;
      #1 check("bad_no_load", {ldA, ldB}, 0);
      @(negedge clk);
      force_bad = 1'b0;
      check("bad_done",      done,       1);
      check("bad_err_flags", err_flags,  1);
      check("bad_reg_a",     reg_a,      20);
      check("bad_reg_b",     reg_b,      6);
      check("bad_iter",      iter_count, 0);

      // Abort together with accept in DONE: abort wins, status cleared
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
      @(posedge clk);
      #1 abort = 1'b0; in_valid = 1'b0;
      check("abort_done",     done,      0);
      check("abort_errs",     err_flags, 0);
      check("abort_ready",    in_ready,  1);
      check("abort_no_load",  ldA,       0);

      // Abort in LOAD_B
      @(negedge clk);
      in_a = 16'd30; in_b = 16'd12; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("lb_ldB",     ldB,     1);
      check("lb_data_in", data_in, 12);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("lb_abort_ready", in_ready,   1);
      check("lb_abort_ld",    {ldA, ldB}, 0);
      @(negedge clk);
      check("lb_abort_idle",  {done, in_ready}, 2'b01);

      // Reset mid-COMPUTE
      @(negedge clk);
      in_a = 16'd100; in_b = 16'd1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_ldA",  ldA,        1);
      check("mid_sel2", sel2,       1);
      check("mid_iter", iter_count, 2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ld",    {ldA, ldB, sel1, sel2, sel_in}, 0);
      check("mid_rst_ready", in_ready,   0);
      check("mid_rst_iter",  iter_count, 0);
      check("mid_rst_data",  data_in,    0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("mid_rel_ready", in_ready, 1);

      // Recovery after reset: (21,14) -> 2 subtractions, gcd 7
      run_op(16'd21, 16'd14, lat, pulses, d1, d2);
      check("g21_latency", lat,        6);
      check("g21_reg_a",   reg_a,      7);
      check("g21_iter",    iter_count, 2);

      check("ld_invariants", bad_ld, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
